// File: rtl/taxi_trip_controller.sv
// Taxi trip sequencer: hire/run/wait/settle FSM, distance counting with
// saturation, fare-stage selects, meter clear and waiting-time tick.
module taxi_trip_controller #(
    parameter int unsigned DW               = 32,
    parameter int unsigned STAGE2_START_10M = 300,
    parameter int unsigned STAGE3_START_10M = 1000,
    parameter int unsigned WAIT_TIMEOUT     = 500,
    parameter int unsigned WAIT_TICK        = 1000,
    parameter int unsigned SETTLE_CYCLES    = 2000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_btn,
    input  logic          stop_btn,
    input  logic          pulse_10m,
    output logic          pulse_10m_out,
    output logic          meter_clear,
    output logic          is_stage_1st,
    output logic          is_stage_2nd,
    output logic          is_stage_3rd,
    output logic [DW-1:0] distance_10m,
    output logic          trip_active,
    output logic          waiting,
    output logic          wait_tick,
    output logic          fare_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_WAITING,
        S_SETTLE
    } state_e;

    localparam logic [DW-1:0] DIST_MAX    = '1;
    localparam logic [DW-1:0] IDLE_LAST   = DW'(WAIT_TIMEOUT - 1);
    localparam logic [DW-1:0] TICK_LAST   = DW'(WAIT_TICK - 1);
    localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] STAGE2_D    = DW'(STAGE2_START_10M);
    localparam logic [DW-1:0] STAGE3_D    = DW'(STAGE3_START_10M);

    state_e        state_q, state_d;
    logic [DW-1:0] dist_q, dist_d;
    logic [DW-1:0] idle_cnt_q, idle_cnt_d;
    logic [DW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] settle_cnt_q, settle_cnt_d;
    logic          pulse_out_q, pulse_out_d;
    logic          clear_q, clear_d;
    logic          tick_q, tick_d;
    logic          stage1_q, stage1_d;
    logic          stage2_q, stage2_d;
    logic          stage3_q, stage3_d;
    logic          active_q, active_d;
    logic          waiting_q, waiting_d;
    logic          fare_q, fare_d;
    logic [DW-1:0] dist_inc;

    assign dist_inc = (dist_q == DIST_MAX) ? dist_q : dist_q + DW'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        dist_d       = dist_q;
        idle_cnt_d   = idle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pulse_out_d  = 1'b0;
        clear_d      = 1'b0;
        tick_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_btn) begin
                    state_d    = S_RUNNING;
                    dist_d     = '0;
                    idle_cnt_d = '0;
                    clear_d    = 1'b1;
                end
            end
            S_RUNNING: begin
                if (stop_btn) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                end else if (pulse_10m) begin
                    dist_d      = dist_inc;
                    idle_cnt_d  = '0;
                    pulse_out_d = 1'b1;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = S_WAITING;
                    wait_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + DW'(1);
                end
            end
            S_WAITING: begin
                if (stop_btn) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                end else if (pulse_10m) begin
                    state_d     = S_RUNNING;
                    dist_d      = dist_inc;
                    idle_cnt_d  = '0;
                    wait_cnt_d  = '0;
                    pulse_out_d = 1'b1;
                end else if (wait_cnt_q == TICK_LAST) begin
                    wait_cnt_d = '0;
                    tick_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + DW'(1);
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status and stage flags are registered from next-state values so they
        // line up with distance_10m in the same cycle.
        active_d  = (state_d == S_RUNNING) || (state_d == S_WAITING);
        waiting_d = (state_d == S_WAITING);
        fare_d    = (state_d == S_SETTLE);
        stage1_d  = active_d && (dist_d < STAGE2_D);
        stage2_d  = active_d && (dist_d >= STAGE2_D) && (dist_d < STAGE3_D);
        stage3_d  = active_d && (dist_d >= STAGE3_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dist_q       <= '0;
            idle_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pulse_out_q  <= 1'b0;
            clear_q      <= 1'b0;
            tick_q       <= 1'b0;
            stage1_q     <= 1'b0;
            stage2_q     <= 1'b0;
            stage3_q     <= 1'b0;
            active_q     <= 1'b0;
            waiting_q    <= 1'b0;
            fare_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dist_q       <= dist_d;
            idle_cnt_q   <= idle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pulse_out_q  <= pulse_out_d;
            clear_q      <= clear_d;
            tick_q       <= tick_d;
            stage1_q     <= stage1_d;
            stage2_q     <= stage2_d;
            stage3_q     <= stage3_d;
            active_q     <= active_d;
            waiting_q    <= waiting_d;
            fare_q       <= fare_d;
        end
    end

    assign pulse_10m_out = pulse_out_q;
    assign meter_clear   = clear_q;
    assign is_stage_1st  = stage1_q;
    assign is_stage_2nd  = stage2_q;
    assign is_stage_3rd  = stage3_q;
    assign distance_10m  = dist_q;
    assign trip_active   = active_q;
    assign waiting       = waiting_q;
    assign wait_tick     = tick_q;
    assign fare_valid    = fare_q;

endmodule

// File: tb/tb_taxi_trip_controller.sv
// Bench for taxi_trip_controller: timestamp-based trip model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_taxi_trip_controller;

    localparam int unsigned DW      = 4;
    localparam int unsigned ST2     = 3;
    localparam int unsigned ST3     = 5;
    localparam int unsigned TO      = 4;
    localparam int unsigned TICK    = 3;
    localparam int unsigned SETTLE  = 5;
    localparam int          DMAX    = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_btn = 1'b0;
    logic          stop_btn = 1'b0;
    logic          pulse_10m = 1'b0;
    logic          pulse_10m_out;
    logic          meter_clear;
    logic          is_stage_1st;
    logic          is_stage_2nd;
    logic          is_stage_3rd;
    logic [DW-1:0] distance_10m;
    logic          trip_active;
    logic          waiting;
    logic          wait_tick;
    logic          fare_valid;

    taxi_trip_controller #(
        .DW(DW), .STAGE2_START_10M(ST2), .STAGE3_START_10M(ST3),
        .WAIT_TIMEOUT(TO), .WAIT_TICK(TICK), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
        .pulse_10m(pulse_10m), .pulse_10m_out(pulse_10m_out),
        .meter_clear(meter_clear), .is_stage_1st(is_stage_1st),
        .is_stage_2nd(is_stage_2nd), .is_stage_3rd(is_stage_3rd),
        .distance_10m(distance_10m), .trip_active(trip_active),
        .waiting(waiting), .wait_tick(wait_tick), .fare_valid(fare_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Trip model: remembers when things happened rather than counting states.
    int edge_n    = 0;
    int last_act  = 0;
    int stop_edge = 0;
    int m_dist    = 0;
    bit in_trip   = 0;
    bit in_settle = 0;
    bit exp_pout  = 0;
    bit exp_clr   = 0;
    bit model_ok  = 0;

    always @(posedge clk) begin
        edge_n   = edge_n + 1;
        exp_pout = 0;
        exp_clr  = 0;
        if (rst) begin
            in_trip   = 0;
            in_settle = 0;
            m_dist    = 0;
            model_ok  = 1;
        end else if (in_trip) begin
            if (stop_btn) begin
                in_trip   = 0;
                in_settle = 1;
                stop_edge = edge_n;
            end else if (pulse_10m) begin
                if (m_dist < DMAX) m_dist = m_dist + 1;
                last_act = edge_n;
                exp_pout = 1;
            end
        end else if (in_settle) begin
            if (edge_n - stop_edge >= int'(SETTLE)) in_settle = 0;
        end else if (start_btn) begin
            in_trip  = 1;
            m_dist   = 0;
            last_act = edge_n;
            exp_clr  = 1;
        end
    end

    function automatic logic [12:0] model_vec();
        int  quiet;
        bit  w, t, s1, s2, s3;
        quiet = edge_n - last_act;
        w  = in_trip && (quiet >= int'(TO));
        t  = in_trip && (quiet > int'(TO)) && (((quiet - int'(TO)) % int'(TICK)) == 0);
        s1 = in_trip && (m_dist < int'(ST2));
        s2 = in_trip && (m_dist >= int'(ST2)) && (m_dist < int'(ST3));
        s3 = in_trip && (m_dist >= int'(ST3));
        return {exp_pout, exp_clr, s1, s2, s3, 4'(m_dist), in_trip, w, t, in_settle};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {pulse_10m_out, meter_clear, is_stage_1st, is_stage_2nd, is_stage_3rd,
                distance_10m, trip_active, waiting, wait_tick, fare_valid};
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            logic [12:0] a, x;
            a = dut_vec();
            x = model_vec();
            n_checks = n_checks + 1;
            if (a === x) n_pass = n_pass + 1;
            else $display("FAIL model_cmp edge %0d: got %b expected %b", edge_n, a, x);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input bit s, input bit t, input bit p);
        start_btn = s;
        stop_btn  = t;
        pulse_10m = p;
        @(posedge clk);
        #1;
    endtask

    int pcount;

    initial begin
        // Reset
        rst = 1'b1;
        step(0, 0, 0);
        step(1, 1, 1);
        chk("reset_outputs", int'(dut_vec()), 0);
        rst = 1'b0;

        // Start: one-cycle clear, stage 1
        step(1, 0, 0);
        chk("start_clear", int'(meter_clear), 1);
        chk("start_stage1", int'(is_stage_1st), 1);
        chk("start_active", int'(trip_active), 1);
        step(0, 0, 0);
        chk("clear_one_cycle", int'(meter_clear), 0);

        // Six pulses across both stage boundaries
        pcount = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1);
            pcount += int'(pulse_10m_out);
            chk("pulse_dist", int'(distance_10m), i);
            chk("pulse_stage", int'({is_stage_1st, is_stage_2nd, is_stage_3rd}),
                (i < 3) ? 4 : ((i < 5) ? 2 : 1));
        end
        chk("pulse_out_count", pcount, 6);

        // Quiet period: waiting after p+4, ticks after p+7 and p+10
        for (int j = 1; j <= 12; j++) begin
            step(0, 0, 0);
            chk("wait_level", int'(waiting), (j >= 4) ? 1 : 0);
            chk("wait_tick", int'(wait_tick), (j == 7 || j == 10) ? 1 : 0);
        end
        step(0, 0, 1);
        chk("resume_waiting", int'(waiting), 0);
        chk("resume_dist", int'(distance_10m), 7);

        // Stop with coincident pulse, then settle while start is held
        step(0, 1, 1);
        chk("stop_dist", int'(distance_10m), 7);
        chk("stop_pout", int'(pulse_10m_out), 0);
        chk("stop_fare", int'(fare_valid), 1);
        for (int j = 1; j <= 5; j++) begin
            step(1, 0, 0);
            chk("settle_fare", int'(fare_valid), (j < 5) ? 1 : 0);
            chk("settle_stages", int'({is_stage_1st, is_stage_2nd, is_stage_3rd}), 0);
            chk("settle_active", int'(trip_active), 0);
        end
        step(0, 0, 0);
        chk("idle_hold_dist", int'(distance_10m), 7);

        // Saturation
        step(1, 0, 0);
        chk("new_trip_dist", int'(distance_10m), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1);
        chk("saturated", int'(distance_10m), 15);

        // Reset in the middle of WAITING
        for (int j = 0; j < 5; j++) step(0, 0, 0);
        chk("pre_rst_wait", int'(waiting), 1);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        chk("mid_rst_outputs", int'(dut_vec()), 0);
        step(1, 0, 0);
        chk("fresh_clear", int'(meter_clear), 1);
        chk("fresh_dist", int'(distance_10m), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0));
        end
        rst = 1'b0;
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
